// File: rtl/cpu_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_pkg
// Description : Shared types and constants for the multi-channel host I/O
//               decoder (FSM state encoding, synchroniser depth, counter
//               width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKW = 2'd2,
    HOLD = 2'd3
  } io_state_t;

  // Number of flops in each strobe synchroniser.
  localparam int SYNC_STAGES = 2;

  // Width needed for a counter that must be able to hold the value 'timeout'.
  function automatic int timeout_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_sync2.sv
`default_nettype none
// ============================================================================
// Module      : io_sync2
// Description : Multi-flop synchroniser for an asynchronous, active-low host
//               strobe. Resets to 1 (strobe inactive).
// Revision    : 1.0 - initial release
// ============================================================================
module io_sync2
  import cpu_io_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw pin into the chain, oldest sample at the top.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Synchroniser flops; reset to the inactive (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cpu_io_multi.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_multi
// Description : Host I/O bus decoder fanning out to NUM_CH register-mapped
//               peripheral channels with req/ack handshake and ack timeout.
//               Optional host WAIT generation is enabled by defining the
//               macro CPU_IO_WAIT_EN; otherwise wait_n is tied high.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_io_multi
  import cpu_io_pkg::*;
#(
  parameter int                  NUM_CH      = 4,
  parameter logic [NUM_CH*6-1:0] BASE_ADDRS  = {6'h26, 6'h27, 6'h28, 6'h29},
  parameter int                  ACK_TIMEOUT = 64,
  parameter logic [7:0]          IDLE_DATA   = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          A,
  input  logic                rd_iorq_n,
  input  logic                wr_iorq_n,
  input  logic [7:0]          cd_in,
  output logic [7:0]          cd_out,
  output logic                cd_oe,
  output logic                cs_n,
  output logic [NUM_CH-1:0]   ch_req,
  output logic                ch_wr,
  output logic [7:0]          ch_wdata,
  input  logic [NUM_CH-1:0]   ch_ack,
  input  logic [NUM_CH*8-1:0] ch_rdata,
  output logic                err,
  output logic                wait_n
);

  localparam int              CNT_W       = timeout_cnt_w(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);

  // Synchronised strobes (active low).
  logic w_rd_s;
  logic w_wr_s;

  io_sync2 u_sync_rd (
    .clk   (clk),
    .reset (reset),
    .d     (rd_iorq_n),
    .q     (w_rd_s)
  );

  io_sync2 u_sync_wr (
    .clk   (clk),
    .reset (reset),
    .d     (wr_iorq_n),
    .q     (w_wr_s)
  );

  // State and datapath registers.
  io_state_t              state_q,   state_d;
  logic [NUM_CH-1:0]      sel_q,     sel_d;
  logic                   wr_q,      wr_d;
  logic [7:0]             wdata_q,   wdata_d;
  logic [7:0]             cd_out_q,  cd_out_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic                   rd_prev_q, rd_prev_d;
  logic                   wr_prev_q, wr_prev_d;
  logic [SYNC_STAGES-1:0] blank_q,   blank_d;

  logic              w_blank_done;
  logic              w_rd_fall;
  logic              w_wr_fall;
  logic              w_start;
  logic              w_found;
  logic [NUM_CH-1:0] w_match_sel;
  logic [7:0]        w_sel_rdata;
  logic              w_strobe_low;
  logic              w_ack_hit;

  // Edge detection. The synchroniser outputs a forced 'high' for the first
  // SYNC_STAGES cycles after reset; the previous-value flops are held low
  // until real pin samples arrive, so a strobe already low at reset release
  // never looks like a fresh falling edge.
  always_comb begin
    blank_d      = {blank_q[SYNC_STAGES-2:0], 1'b1};
    w_blank_done = blank_q[SYNC_STAGES-1];
    rd_prev_d    = w_blank_done ? w_rd_s : 1'b0;
    wr_prev_d    = w_blank_done ? w_wr_s : 1'b0;
    w_rd_fall    = rd_prev_q & ~w_rd_s;
    w_wr_fall    = wr_prev_q & ~w_wr_s;
  end

  // Address decode: one-hot select of the lowest-index matching channel.
  always_comb begin
    w_match_sel = '0;
    w_found     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && (A == BASE_ADDRS[i*6 +: 6])) begin
        w_match_sel[i] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  // Read-data mux and ack filter for the channel owning the current access.
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel_rdata = w_sel_rdata | (ch_rdata[i*8 +: 8] & {8{sel_q[i]}});
    end
    w_ack_hit    = |(ch_ack & sel_q);
    w_strobe_low = wr_q ? ~w_wr_s : ~w_rd_s;
    // Exactly one strobe falling while the other stays high, with a match.
    w_start      = ((w_rd_fall & w_wr_s) | (w_wr_fall & w_rd_s)) & w_found;
  end

  // Access FSM: next state, latched access attributes, timeout counter.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    cd_out_d = cd_out_q;
    cnt_d    = '0;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_start) begin
          sel_d   = w_match_sel;
          wr_d    = w_wr_fall;
          wdata_d = cd_in;
          state_d = REQ;
        end
      end
      REQ: begin
        if (w_ack_hit) begin
          if (!wr_q) cd_out_d = w_sel_rdata;
          state_d = HOLD;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = ACKW;
        end
      end
      ACKW: begin
        if (!w_strobe_low) begin
          // Host gave up; any ack arriving later lands in IDLE and is dropped.
          state_d = IDLE;
        end else if (w_ack_hit) begin
          if (!wr_q) cd_out_d = w_sel_rdata;
          state_d = HOLD;
        end else if (cnt_q == TIMEOUT_VAL) begin
          err = 1'b1;
          if (!wr_q) cd_out_d = IDLE_DATA;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!w_strobe_low) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus-facing outputs decoded from the current state. The select and
  // output-enable drop in the same cycle the synchronised strobe returns high.
  always_comb begin
    ch_req = '0;
    cs_n   = 1'b1;
    cd_oe  = 1'b0;
    case (state_q)
      REQ: begin
        ch_req = sel_q;
        cs_n   = 1'b0;
      end
      ACKW: cs_n = ~w_strobe_low;
      HOLD: begin
        cs_n  = ~w_strobe_low;
        cd_oe = ~wr_q & w_strobe_low;
      end
      default: ;
    endcase
  end

  assign ch_wr    = wr_q;
  assign ch_wdata = wdata_q;
  assign cd_out   = cd_out_q;

`ifdef CPU_IO_WAIT_EN
  // Stall the host from request until ack or timeout.
  assign wait_n = ~((state_q == REQ) | (state_q == ACKW));
`else
  assign wait_n = 1'b1;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      cd_out_q  <= '0;
      cnt_q     <= '0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      cd_out_q  <= cd_out_d;
      cnt_q     <= cnt_d;
      rd_prev_q <= rd_prev_d;
      wr_prev_q <= wr_prev_d;
      blank_q   <= blank_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_io_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_io_multi
// Description : Self-checking bench for cpu_io_multi. Each access is predicted
//               from pin-level timing: req 3 cycles after the strobe falls,
//               outcome (ack / timeout / abandon) from ack delay vs. strobe
//               length, end of access 2 cycles after the strobe rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_io_multi;

  localparam int NUM_CH = 4;
  localparam int TMO    = 64;
  // ch3=26, ch2=2A, ch1=26, ch0=10 : ch1 and ch3 overlap to exercise priority.
  localparam logic [23:0] BASES = {6'h26, 6'h2A, 6'h26, 6'h10};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  A = '0;
  logic        rd_iorq_n = 1'b1;
  logic        wr_iorq_n = 1'b1;
  logic [7:0]  cd_in = '0;
  logic [7:0]  cd_out;
  logic        cd_oe;
  logic        cs_n;
  logic [3:0]  ch_req;
  logic        ch_wr;
  logic [7:0]  ch_wdata;
  logic [3:0]  ch_ack = '0;
  logic [31:0] ch_rdata = '0;
  logic        err;
  logic        wait_n;

  int tests = 0;
  int fails = 0;

  logic [5:0] base_tbl [NUM_CH] = '{6'h10, 6'h26, 6'h2A, 6'h26};

  cpu_io_multi #(
    .NUM_CH      (NUM_CH),
    .BASE_ADDRS  (BASES),
    .ACK_TIMEOUT (TMO),
    .IDLE_DATA   (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .rd_iorq_n (rd_iorq_n),
    .wr_iorq_n (wr_iorq_n),
    .cd_in     (cd_in),
    .cd_out    (cd_out),
    .cd_oe     (cd_oe),
    .cs_n      (cs_n),
    .ch_req    (ch_req),
    .ch_wr     (ch_wr),
    .ch_wdata  (ch_wdata),
    .ch_ack    (ch_ack),
    .ch_rdata  (ch_rdata),
    .err       (err),
    .wait_n    (wait_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc,
                       input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_chan(input logic [5:0] addr);
    for (int i = 0; i < NUM_CH; i++) begin
      if (base_tbl[i] == addr) return i;
    end
    return -1;
  endfunction

  task automatic check_idle(input string tag, input int cyc);
    check({tag, ".ch_req"}, cyc, 16'(ch_req), 16'h0);
    check({tag, ".cs_n"},   cyc, 16'(cs_n),   16'h1);
    check({tag, ".cd_oe"},  cyc, 16'(cd_oe),  16'h0);
    check({tag, ".err"},    cyc, 16'(err),    16'h0);
    check({tag, ".wait_n"}, cyc, 16'(wait_n), 16'h1);
  endtask

  // One host access. d = ack delay in cycles after the req cycle (-1: never),
  // len = number of cycles the strobe pin is held low.
  task automatic access(input bit is_wr, input logic [5:0] addr,
                        input logic [7:0] data, input int d, input int len,
                        input logic [31:0] rdw);
    int         ch;
    int         tdone;
    int         last;
    int         wait_end;
    bit         matched;
    bit         aband;
    logic [7:0] exp_out;
    logic [3:0] exp_req;
    logic [3:0] ack_v;
    bit         exp_oe;
    ch       = exp_chan(addr);
    matched  = (ch >= 0);
    tdone    = (d >= 0) ? 4 + d : 4 + TMO;       // first HOLD cycle
    aband    = (len + 2) < tdone;                // strobe seen high before done
    exp_out  = 8'hFF;
    if (matched && d >= 0) exp_out = rdw[ch*8 +: 8];
    wait_end = (tdone - 1 < len + 2) ? tdone - 1 : len + 2;
    last     = len + 4;
    if (d >= 0 && 3 + d + 3 > last) last = 3 + d + 3;

    A        = addr;
    cd_in    = data;
    ch_rdata = rdw;
    if (is_wr) wr_iorq_n = 1'b0;
    else       rd_iorq_n = 1'b0;

    for (int n = 1; n <= last; n++) begin
      tick();
      exp_req = (matched && n == 3) ? 4'(1 << ch) : 4'h0;
      exp_oe  = matched && !is_wr && !aband && n >= tdone && n <= len + 1;
      check("ch_req", n, 16'(ch_req), 16'(exp_req));
      check("cs_n", n, 16'(cs_n), 16'(!(matched && n >= 3 && n <= len + 1)));
      check("cd_oe", n, 16'(cd_oe), 16'(exp_oe));
      check("err", n, 16'(err),
            16'(matched && d < 0 && !aband && n == 3 + TMO));
`ifdef CPU_IO_WAIT_EN
      check("wait_n", n, 16'(wait_n), 16'(!(matched && n >= 3 && n <= wait_end)));
`else
      check("wait_n", n, 16'(wait_n), 16'h1);
`endif
      if (exp_oe) check("cd_out", n, 16'(cd_out), 16'(exp_out));
      if (matched && n == 3) begin
        check("ch_wr", n, 16'(ch_wr), 16'(is_wr));
        if (is_wr) check("ch_wdata", n, 16'(ch_wdata), 16'(data));
      end
      // Inputs for the next cycle.
      ack_v = '0;
      if (matched && d >= 0 && n == 3 + d) ack_v[ch] = 1'b1;
      if (matched && n == 4) ack_v[(ch + 1) % NUM_CH] = 1'b1;  // foreign ack
      ch_ack = ack_v;
      if (n == len) begin
        rd_iorq_n = 1'b1;
        wr_iorq_n = 1'b1;
      end
    end
    ch_ack = '0;
  endtask

  initial begin
    logic [5:0] addr_pick [5];
    addr_pick = '{6'h10, 6'h26, 6'h2A, 6'h3F, 6'h00};

    // Reset values.
    repeat (3) tick();
    check_idle("rst", 0);
    check("rst.cd_out",   0, 16'(cd_out),   16'h0);
    check("rst.ch_wr",    0, 16'(ch_wr),    16'h0);
    check("rst.ch_wdata", 0, 16'(ch_wdata), 16'h0);
    reset = 1'b0;
    repeat (3) tick();

    // Write to ch1 (also priority over ch3 at the same address), ack next cycle.
    access(1'b1, 6'h26, 8'h5A, 1, 10, 32'h0);
    // Read from ch2, ack 5 cycles after req.
    access(1'b0, 6'h2A, 8'h00, 5, 14, 32'h00C3_0000);
    // Timeout read on ch0.
    access(1'b0, 6'h10, 8'h00, -1, 72, 32'h1234_5678);
    // Read with 7-cycle ack latency.
    access(1'b0, 6'h26, 8'h00, 7, 14, 32'h0000_9E00);

    // Reset during ACKW of a write with no ack.
    A = 6'h2A; cd_in = 8'hA5; wr_iorq_n = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check_idle("midrst", 7);
    check("midrst.cd_out",   7, 16'(cd_out),   16'h0);
    check("midrst.ch_wr",    7, 16'(ch_wr),    16'h0);
    check("midrst.ch_wdata", 7, 16'(ch_wdata), 16'h0);
    reset = 1'b0;
    // Strobe still low across reset release is not a new access.
    for (int n = 8; n < 16; n++) begin
      tick();
      check_idle("postrst", n);
    end
    wr_iorq_n = 1'b1;
    repeat (4) tick();

    // Unmatched address.
    access(1'b0, 6'h3F, 8'h00, 2, 6, 32'hFFFF_FFFF);
    // Both strobes low together.
    A = 6'h26; rd_iorq_n = 1'b0; wr_iorq_n = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check_idle("both", n);
    end
    rd_iorq_n = 1'b1; wr_iorq_n = 1'b1;
    repeat (4) tick();

    // Explicit priority read with ack in the req cycle.
    access(1'b0, 6'h26, 8'h00, 0, 5, 32'hAB00_CD00);
    // Abandonment: strobe released long before a late ack.
    access(1'b0, 6'h2A, 8'h00, 9, 5, 32'h0077_0000);

    // Randomised accesses.
    for (int k = 0; k < 40; k++) begin
      logic [5:0] a;
      a = addr_pick[$urandom_range(0, 4)];
      if (a == 6'h00) a = 6'($urandom);
      access(1'($urandom), a, 8'($urandom), int'($urandom_range(0, 10)),
             int'($urandom_range(3, 14)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
